// File: rtl/jtag_vio_pkg.sv
// rtl/jtag_vio_pkg.sv - shared opcodes, FSM states and frame sizing for the JTAG VIO driver
package jtag_vio_pkg;

    localparam logic [7:0] OP_WRITE = 8'hA5;
    localparam logic [7:0] OP_PULSE = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPT,
        ST_SHIFT,
        ST_UPD,
        ST_PULSE
    } vio_state_e;

    // DR carries an 8-bit opcode below the payload
    function automatic int dr_w(input int out_w);
        return out_w + 8;
    endfunction

endpackage

// File: rtl/jtag_sig_sync.sv
// rtl/jtag_sig_sync.sv - 2-FF synchronisers and edge strobes for the ER2 JTAG signals
module jtag_sig_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tck_i,
    input  logic tdi_i,
    input  logic enable_i,
    input  logic shift_dr_capture_dr_i,
    input  logic update_dr_i,
    output logic tck_rise,
    output logic tck_fall,
    output logic upd_rise,
    output logic tdi_s,
    output logic enable_s,
    output logic sdc_s
);

    // bit order: {update, shift/capture, enable, tdi, tck}
    logic [4:0] meta_q;
    logic [4:0] sync_q;
    logic [4:0] lvl_q;

    // Strobes are registered so they line up with lvl_q, three clocks after the pin edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q   <= '0;
            sync_q   <= '0;
            lvl_q    <= '0;
            tck_rise <= 1'b0;
            tck_fall <= 1'b0;
            upd_rise <= 1'b0;
        end else begin
            meta_q   <= {update_dr_i, shift_dr_capture_dr_i, enable_i, tdi_i, tck_i};
            sync_q   <= meta_q;
            lvl_q    <= sync_q;
            tck_rise <= sync_q[0] & ~lvl_q[0];
            tck_fall <= ~sync_q[0] & lvl_q[0];
            upd_rise <= sync_q[4] & ~lvl_q[4];
        end
    end

    assign tdi_s    = lvl_q[1];
    assign enable_s = lvl_q[2];
    assign sdc_s    = lvl_q[3];

endmodule

// File: rtl/jtag_vio_drv.sv
// rtl/jtag_vio_drv.sv - JTAG ER2 virtual I/O: framed DR writes drive vio_o, probe_i read back
module jtag_vio_drv
    import jtag_vio_pkg::*;
#(
    parameter int               OUT_W     = 8,
    parameter int               IN_W      = 3,
    parameter logic [OUT_W-1:0] INIT_VAL  = '0,
    parameter int               PULSE_LEN = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tck_i,
    input  logic             tdi_i,
    input  logic             enable_i,
    input  logic             shift_dr_capture_dr_i,
    input  logic             update_dr_i,
    output logic             tdo_o,
    input  logic [IN_W-1:0]  probe_i,
    output logic [OUT_W-1:0] vio_o,
    output logic             vio_stb_o,
    output logic             frame_err_o
);

    localparam int DR_W = dr_w(OUT_W);
    localparam int BCW  = $clog2(DR_W + 2);
    localparam int PCW  = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    logic tck_rise, tck_fall, upd_rise;
    logic tdi_s, enable_s, sdc_s;

    vio_state_e       state;
    logic [DR_W-1:0]  sr;
    logic [BCW-1:0]   bit_cnt;
    logic [PCW-1:0]   pulse_cnt;
    logic [OUT_W-1:0] restore_q;
    logic             arm_q;
    logic [7:0]       opcode;
    logic [OUT_W-1:0] payload;

    assign opcode  = sr[7:0];
    assign payload = sr[DR_W-1:8];

    jtag_sig_sync u_sync (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .tck_i                 (tck_i),
        .tdi_i                 (tdi_i),
        .enable_i              (enable_i),
        .shift_dr_capture_dr_i (shift_dr_capture_dr_i),
        .update_dr_i           (update_dr_i),
        .tck_rise              (tck_rise),
        .tck_fall              (tck_fall),
        .upd_rise              (upd_rise),
        .tdi_s                 (tdi_s),
        .enable_s              (enable_s),
        .sdc_s                 (sdc_s)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            sr          <= '0;
            bit_cnt     <= '0;
            pulse_cnt   <= '0;
            restore_q   <= INIT_VAL;
            arm_q       <= 1'b1;
            vio_o       <= INIT_VAL;
            tdo_o       <= 1'b0;
            vio_stb_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            vio_stb_o   <= 1'b0;
            frame_err_o <= 1'b0;
            // A frame already in flight when a pulse ends must not be captured mid-way
            if (!sdc_s)
                arm_q <= 1'b1;

            if (state == ST_CAPT || state == ST_SHIFT) begin
                if (tck_fall)
                    tdo_o <= sr[0];
            end else begin
                tdo_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (enable_s && sdc_s && tck_rise && arm_q) begin
                        sr      <= DR_W'(probe_i);
                        bit_cnt <= '0;
                        state   <= ST_CAPT;
                    end
                end
                ST_CAPT, ST_SHIFT: begin
                    // The capture-exit rise is the first shift edge, as in Shift-DR
                    if (!enable_s)
                        state <= ST_IDLE;
                    else if (upd_rise)
                        state <= ST_UPD;
                    else if (tck_rise && sdc_s) begin
                        sr <= {tdi_s, sr[DR_W-1:1]};
                        if (bit_cnt != BCW'(DR_W + 1))
                            bit_cnt <= bit_cnt + BCW'(1);
                        state <= ST_SHIFT;
                    end
                end
                ST_UPD: begin
                    state <= ST_IDLE;
                    if (enable_s) begin
                        if (bit_cnt != BCW'(DR_W))
                            frame_err_o <= 1'b1;
                        else if (opcode == OP_WRITE) begin
                            vio_o     <= payload;
                            vio_stb_o <= 1'b1;
                        end else if (opcode == OP_PULSE) begin
                            restore_q <= vio_o;
                            vio_o     <= payload;
                            vio_stb_o <= 1'b1;
                            pulse_cnt <= PCW'(PULSE_LEN - 1);
                            arm_q     <= 1'b0;
                            state     <= ST_PULSE;
                        end else
                            frame_err_o <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    arm_q <= 1'b0;
                    if (pulse_cnt == '0) begin
                        vio_o     <= restore_q;
                        vio_stb_o <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        pulse_cnt <= pulse_cnt - PCW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_vio_drv.sv
// tb/tb_jtag_vio_drv.sv - scoreboard bench for jtag_vio_drv
module tb_jtag_vio_drv;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tck = 1'b0;
    logic       tdi = 1'b0;
    logic       en  = 1'b0;
    logic       sdc = 1'b0;
    logic       upd = 1'b0;
    logic [2:0] probe = 3'b000;
    logic       tdo;
    logic [7:0] vio;
    logic       stb;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_evt = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] vio;
        int         gap;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    jtag_vio_drv dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .tck_i                 (tck),
        .tdi_i                 (tdi),
        .enable_i              (en),
        .shift_dr_capture_dr_i (sdc),
        .update_dr_i           (upd),
        .tdo_o                 (tdo),
        .probe_i               (probe),
        .vio_o                 (vio),
        .vio_stb_o             (stb),
        .frame_err_o           (err)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every strobe pops one expected event
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (stb || err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event stb=%0b err=%0b vio=%h required=none", stb, err, vio);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", {14'd0, stb, err}, {14'd0, !e.is_err, e.is_err});
                    check("event_vio", 16'(vio), 16'(e.vio));
                    if (e.gap >= 0)
                        check("event_gap", 16'(cyc - last_evt), 16'(e.gap));
                end
                last_evt = cyc;
            end
        end
    end

    task automatic tck_cyc(output logic t);
        #24;
        t = tdo;
        #1;
        tck = 1'b1;
        #50;
        tck = 1'b0;
        #25;
    endtask

    task automatic run_frame(input int nbits, input logic [15:0] data,
                             input bit rd, input logic [15:0] rd_exp);
        logic t;
        @(negedge clk);
        #2;
        en  = 1'b1;
        sdc = 1'b1;
        tdi = 1'b0;
        tck_cyc(t);
        for (int i = 0; i < nbits; i++) begin
            tdi = data[i];
            tck_cyc(t);
            if (rd)
                check($sformatf("tdo_bit%0d", i), {15'd0, t}, {15'd0, rd_exp[i]});
        end
        sdc = 1'b0;
        tdi = 1'b0;
        tck_cyc(t);
        upd = 1'b1;
        tck_cyc(t);
    endtask

    task automatic end_frame();
        logic t;
        upd = 1'b0;
        en  = 1'b0;
        tck_cyc(t);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 16'(exp_q.size()), 16'd0);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic t;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) tck_cyc(t);
        check("reset_vio", 16'(vio), 16'h0000);
        check("reset_tdo", {15'd0, tdo}, 16'd0);
        check("reset_stb", {15'd0, stb}, 16'd0);
        check("reset_err", {15'd0, err}, 16'd0);

        exp_q.push_back('{1'b0, 8'h3C, -1});
        run_frame(16, 16'h3CA5, 1'b0, 16'h0000);
        end_frame();
        drain("write");
        check("write_vio", 16'(vio), 16'h003C);

        probe = 3'b101;
        exp_q.push_back('{1'b0, 8'h3C, -1});
        run_frame(16, 16'h3CA5, 1'b1, 16'h0005);
        end_frame();
        drain("readback");
        repeat (5) @(negedge clk);
        check("idle_tdo", {15'd0, tdo}, 16'd0);

        exp_q.push_back('{1'b0, 8'hFF, -1});
        exp_q.push_back('{1'b0, 8'h3C, 16});
        run_frame(16, 16'hFF5A, 1'b0, 16'h0000);
        end_frame();
        drain("pulse");
        check("pulse_restore_vio", 16'(vio), 16'h003C);

        exp_q.push_back('{1'b1, 8'h3C, -1});
        run_frame(15, 16'h3CA5, 1'b0, 16'h0000);
        end_frame();
        drain("short");

        exp_q.push_back('{1'b1, 8'h3C, -1});
        run_frame(16, 16'h1200, 1'b0, 16'h0000);
        end_frame();
        drain("badop");
        check("err_vio_unchanged", 16'(vio), 16'h003C);

        // Reset part-way through a shift
        @(negedge clk);
        #2;
        en  = 1'b1;
        sdc = 1'b1;
        tck_cyc(t);
        for (int i = 0; i < 8; i++) begin
            tdi = i[0];
            tck_cyc(t);
        end
        rst = 1'b1;
        #1;
        check("rst_shift_vio", 16'(vio), 16'h0000);
        check("rst_shift_tdo", {15'd0, tdo}, 16'd0);
        en  = 1'b0;
        sdc = 1'b0;
        tdi = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset part-way through a pulse: no restore event may follow
        exp_q.push_back('{1'b0, 8'h77, -1});
        run_frame(16, 16'h775A, 1'b0, 16'h0000);
        rst = 1'b1;
        #1;
        check("rst_pulse_vio", 16'(vio), 16'h0000);
        en  = 1'b0;
        upd = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain("rst_pulse");
        repeat (30) @(negedge clk);
        check("rst_pulse_hold", 16'(vio), 16'h0000);

        exp_q.push_back('{1'b0, 8'h96, -1});
        run_frame(16, 16'h96A5, 1'b0, 16'h0000);
        end_frame();
        drain("post_rst");
        check("post_rst_vio", 16'(vio), 16'h0096);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
